// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP encoding and the response record used by the fetch responder.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic            fault;
  } fetch_rsp_t;
endpackage

// File: rtl/fetch_rsp_fifo.sv
// fetch_rsp_fifo: in-order response buffer with first-word fall-through, synchronous clear and occupancy count.
module fetch_rsp_fifo import fetch_pkg::*; #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_rsp_t               din_i,
  output fetch_rsp_t               dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  fetch_rsp_t    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    wptr_d  = clr_i ? '0 : push_i ? inc(wptr_q) : wptr_q;
    rptr_d  = clr_i ? '0 : pop_i ? inc(rptr_q) : rptr_q;
    count_d = clr_i ? '0 : count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (push_i && !clr_i) mem_q[wptr_q] <= din_i;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: instruction ROM with one read stage and a response buffer behind a valid/ready channel.
module instr_fetch_responder import fetch_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_instr,
  output logic [XLEN-1:0] rsp_addr,
  output logic            rsp_fault
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  logic [XLEN-1:0] rom [DEPTH_WORDS];
  fetch_rsp_t      rd_q, rd_d, fifo_head, head;
  logic            inflight_q, inflight_d, accept, pop, push, fault;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  initial
    for (int i = 0; i < int'(DEPTH_WORDS); i++) rom[i] = '0;
`ifndef IMEM_FAULT_EN
  logic unused_addr;
  assign unused_addr = ^{req_addr[1:0], req_addr[XLEN-1:AW+2]};
`endif
  always_comb begin
`ifdef IMEM_FAULT_EN
    fault = |req_addr[1:0] || {2'b00, req_addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS);
`else
    fault = 1'b0;
`endif
    rd_d = '{instr: fault ? INSTR_NOP : rom[req_addr[AW+1:2]], addr: req_addr, fault: fault};
    head       = count != '0 ? fifo_head : rd_q;
    rsp_valid  = !reset && !flush && (count != '0 || inflight_q);
    pop        = rsp_valid && rsp_ready;
    occ        = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    req_ready  = !reset && occ < (CW+1)'(FIFO_DEPTH);
    accept     = req_valid && req_ready;
    inflight_d = accept;
    push       = inflight_q && !flush && !(count == '0 && pop);
    rsp_instr  = head.instr;
    rsp_addr   = head.addr;
    rsp_fault  = head.fault;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      inflight_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (accept) rd_q <= rd_d;
    end
  fetch_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop && count != '0),
    .din_i   (rd_q),
    .dout_o  (fifo_head),
    .count_o (count)
  );
endmodule
